// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter: one log2 shift step per stage, a register after every
// step, and a whole-pipe stall driven by the output handshake.
module pipelined_shifter #(
  parameter int WIDTH = 32,
  parameter int TAGW  = 5,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [2:0]       in_op,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAGW-1:0]  out_tag,
  output logic             out_illegal
);

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  logic             adv;
  logic             in_illegal;

  logic [WIDTH-1:0] data_reg    [SHW];
  logic [SHW-1:0]   amt_reg     [SHW];
  logic [2:0]       op_reg      [SHW];
  logic [TAGW-1:0]  tag_reg     [SHW];
  logic             illegal_reg [SHW];
  logic             valid_reg   [SHW];

  logic [WIDTH-1:0] data_next    [SHW];
  logic [SHW-1:0]   amt_next     [SHW];
  logic [2:0]       op_next      [SHW];
  logic [TAGW-1:0]  tag_next     [SHW];
  logic             illegal_next [SHW];
  logic             valid_next   [SHW];

  // SRA needs no separate sign register: an arithmetic step keeps the MSB, so the
  // entry sign is always the current MSB.
  function automatic logic [WIDTH-1:0] shift_by(
    input logic [WIDTH-1:0] d,
    input logic [2:0]       op,
    input logic             en,
    input int               s
  );
    shift_by = d;
    if (en) begin
      case (op)
        OP_SLL:  shift_by = d << s;
        OP_SRL:  shift_by = d >> s;
        OP_SRA:  shift_by = $signed(d) >>> s;
        OP_ROL:  shift_by = (d << s) | (d >> (WIDTH - s));
        OP_ROR:  shift_by = (d >> s) | (d << (WIDTH - s));
        default: shift_by = '0;
      endcase
    end
  endfunction

  assign adv        = !valid_reg[SHW-1] || out_ready;
  assign in_ready   = adv;
  assign in_illegal = (in_op > OP_ROR);

  genvar gi;
  for (gi = 0; gi < SHW; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      // Reserved ops are zeroed on entry so every later step just passes zero along.
      assign data_next[gi]    = shift_by(in_illegal ? '0 : in_data, in_op, in_amt[gi], 1);
      assign amt_next[gi]     = in_amt;
      assign op_next[gi]      = in_op;
      assign tag_next[gi]     = in_tag;
      assign illegal_next[gi] = in_illegal;
      assign valid_next[gi]   = in_valid;
    end else begin : g_body
      assign data_next[gi]    = shift_by(data_reg[gi-1], op_reg[gi-1], amt_reg[gi-1][gi], 1 << gi);
      assign amt_next[gi]     = amt_reg[gi-1];
      assign op_next[gi]      = op_reg[gi-1];
      assign tag_next[gi]     = tag_reg[gi-1];
      assign illegal_next[gi] = illegal_reg[gi-1];
      assign valid_next[gi]   = valid_reg[gi-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < SHW; k++) begin
        valid_reg[k]   <= 1'b0;
        data_reg[k]    <= '0;
        amt_reg[k]     <= '0;
        op_reg[k]      <= '0;
        tag_reg[k]     <= '0;
        illegal_reg[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < SHW; k++) begin
        if (flush) begin
          valid_reg[k] <= 1'b0;
        end else if (adv) begin
          valid_reg[k] <= valid_next[k];
        end
        if (adv) begin
          data_reg[k]    <= data_next[k];
          amt_reg[k]     <= amt_next[k];
          op_reg[k]      <= op_next[k];
          tag_reg[k]     <= tag_next[k];
          illegal_reg[k] <= illegal_next[k];
        end
      end
    end
  end

  assign out_valid   = valid_reg[SHW-1];
  assign out_data    = data_reg[SHW-1];
  assign out_tag     = tag_reg[SHW-1];
  assign out_illegal = illegal_reg[SHW-1];

endmodule
